// File: rtl/jtadpcm_timing_if.sv
// Control inputs and timing strobes exchanged between the core and the
// ADPCM sample-rate generator.
interface jtadpcm_timing_if #(
  parameter int CHANNELS = 4,
  parameter int SCW      = 16
);
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic           cen;
  logic           ss;
  logic           sync;
  logic           cen_sr;
  logic           cen_sr4;
  logic           cen_sr4b;
  logic           cen_sr32;
  logic [CHW-1:0] ch;
  logic           ss_act;
  logic [SCW-1:0] smp_cnt;

  modport master (
    output cen, ss, sync,
    input  cen_sr, cen_sr4, cen_sr4b, cen_sr32, ch, ss_act, smp_cnt
  );

  modport slave (
    input  cen, ss, sync,
    output cen_sr, cen_sr4, cen_sr4b, cen_sr32, ch, ss_act, smp_cnt
  );
endinterface

// File: rtl/jtadpcm_timing.sv
// Sample-rate strobe generator: a cen prescaler feeds a slot counter, and the
// slot index is decoded into sample, 4x, shifted 4x and per-slot strobes.
module jtadpcm_timing #(
  parameter int DIV0     = 5,
  parameter int DIV1     = 4,
  parameter int ACTIVE   = 32,
  parameter int SLOTS    = 33,
  parameter int CHANNELS = 4,
  parameter int SCW      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  jtadpcm_timing_if.slave  bus
);
  localparam int CW  = $clog2(SLOTS);
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SH  = $clog2(ACTIVE / CHANNELS);

  localparam logic [CW-1:0] ACT_C  = CW'(ACTIVE);
  localparam logic [CW-1:0] LAST_C = CW'(SLOTS - 1);
  localparam logic [CW-1:0] QMASK  = CW'(ACTIVE / 4 - 1);
  localparam logic [CW-1:0] HALFQ  = CW'(ACTIVE / 8);
  localparam logic [2:0]    LIM0   = 3'(DIV0 - 1);
  localparam logic [2:0]    LIM1   = 3'(DIV1 - 1);

  logic [2:0]     base_reg;
  logic [CW-1:0]  cnt_reg;
  logic           sr_reg, sr4_reg, sr4b_reg, sr32_reg;
  logic [CHW-1:0] ch_reg;
  logic           ss_act_reg;
  logic [SCW-1:0] smp_reg;
  logic           started_reg;

  logic [2:0] lim;
  logic       slot_start, slot_end, active_slot, smp_end;

  assign lim         = ss_act_reg ? LIM1 : LIM0;
  assign slot_start  = (base_reg == 3'd0);
  assign slot_end    = (base_reg == lim);
  assign active_slot = (cnt_reg < ACT_C);
  assign smp_end     = slot_end && (cnt_reg == LAST_C);

  // cnt holds the index of the slot in progress, so it advances at the end of
  // each slot and the decode at base==0 always sees the slot being started.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_reg    <= 3'd0;
      cnt_reg     <= '0;
      sr_reg      <= 1'b0;
      sr4_reg     <= 1'b0;
      sr4b_reg    <= 1'b0;
      sr32_reg    <= 1'b0;
      ch_reg      <= '0;
      ss_act_reg  <= 1'b0;
      smp_reg     <= '0;
      started_reg <= 1'b0;
    end else begin
      sr_reg      <= 1'b0;
      sr4_reg     <= 1'b0;
      sr4b_reg    <= 1'b0;
      sr32_reg    <= 1'b0;
      started_reg <= 1'b1;
      if (!started_reg)
        ss_act_reg <= bus.ss;
      if (bus.sync) begin
        base_reg   <= 3'd0;
        cnt_reg    <= '0;
        ss_act_reg <= bus.ss;
      end else if (bus.cen) begin
        if (slot_start) begin
          sr32_reg <= active_slot;
          sr4_reg  <= active_slot && ((cnt_reg & QMASK) == '0);
          sr4b_reg <= active_slot && ((cnt_reg & QMASK) == HALFQ);
          sr_reg   <= (cnt_reg == '0);
          if (active_slot)
            ch_reg <= CHW'(cnt_reg >> SH);
        end
        if (slot_end) begin
          base_reg <= 3'd0;
          if (smp_end) begin
            cnt_reg    <= '0;
            ss_act_reg <= bus.ss;
            smp_reg    <= smp_reg + SCW'(1);
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end else begin
          base_reg <= base_reg + 3'd1;
        end
      end
    end
  end

  assign bus.cen_sr   = sr_reg;
  assign bus.cen_sr4  = sr4_reg;
  assign bus.cen_sr4b = sr4b_reg;
  assign bus.cen_sr32 = sr32_reg;
  assign bus.ch       = ch_reg;
  assign bus.ss_act   = ss_act_reg;
  assign bus.smp_cnt  = smp_reg;
endmodule
